// File: rtl/mips_fetch_pkg.sv
// Shared constants and helpers for the dual-issue instruction fetch path.
package mips_fetch_pkg;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
    localparam int unsigned FETCH_BYTES = 8;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        while ((32'd1 << width) < value) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/fetchq_ram.sv
// Fetch queue storage: two adjacent write ports at tail and two adjacent
// combinational read ports at head, all indices wrapping modulo DEPTH.
module fetchq_ram
    import mips_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned IDX_W = clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we0,
    input  logic             i_we1,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic [31:0]      i_wdata0,
    input  logic [31:0]      i_wdata1,
    input  logic [IDX_W-1:0] i_raddr,
    output logic [31:0]      o_rdata0,
    output logic [31:0]      o_rdata1
);

    logic [31:0]      r_mem [DEPTH];
    logic [IDX_W-1:0] w_waddr1;
    logic [IDX_W-1:0] w_raddr1;

    assign w_waddr1 = i_waddr + IDX_W'(1);
    assign w_raddr1 = i_raddr + IDX_W'(1);

    always_ff @(posedge i_clk) begin
        if (i_we0) begin
            r_mem[i_waddr] <= i_wdata0;
        end
        if (i_we1) begin
            r_mem[w_waddr1] <= i_wdata1;
        end
    end

    assign o_rdata0 = r_mem[i_raddr];
    assign o_rdata1 = r_mem[w_raddr1];

endmodule

// File: rtl/dual_fetch_queue.sv
// Instruction fetch buffer for the dual-issue core: issues 8-byte fetches,
// queues returned word pairs and presents the two oldest words to decode.
module dual_fetch_queue
    import mips_fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        fetch_req,
    output logic [31:0] fetch_addr,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_data0,
    input  logic [31:0] fetch_data1,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic [31:0] instr2,
    output logic [1:0]  avail,
    input  logic [1:0]  deq,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int unsigned IDX_W = clog2(DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;

    logic [IDX_W-1:0] r_head;
    logic [IDX_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic [1:0]       r_outstanding;
    logic [1:0]       r_discard;
    logic [31:0]      r_fetch_addr;
    logic             r_skip_first;
    logic [31:0]      r_pc;

    logic [IDX_W-1:0] w_head_nxt;
    logic [IDX_W-1:0] w_tail_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic [1:0]       w_outstanding_nxt;
    logic [1:0]       w_discard_nxt;
    logic [31:0]      w_fetch_addr_nxt;
    logic             w_skip_first_nxt;
    logic [31:0]      w_pc_nxt;

    logic [1:0]       w_avail;
    logic [1:0]       w_deq_eff;
    logic [1:0]       w_enq;
    logic             w_space_ok;
    logic             w_accept;
    logic             w_we1;
    logic [31:0]      w_wdata0;
    logic [31:0]      w_rdata0;
    logic [31:0]      w_rdata1;
    logic             w_unused;

    assign w_unused = ^redirect_pc[1:0];

    // Space check reserves two slots for every in-flight fetch, including
    // ones that will be discarded, so the queue can never overflow.
    assign w_space_ok = (32'(r_count) + 2 * 32'(r_outstanding) + 2) <= DEPTH;
    assign fetch_req  = !reset && !redirect && (32'(r_outstanding) < MAX_OUT) && w_space_ok;
    assign fetch_addr = r_fetch_addr;

    assign w_avail   = (r_count >= CNT_W'(2)) ? 2'd2 : r_count[1:0];
    assign w_deq_eff = (deq > w_avail) ? w_avail : deq;

    assign w_accept = fetch_valid && (r_discard == 2'd0) && !redirect;
    assign w_enq    = !w_accept ? 2'd0 : (r_skip_first ? 2'd1 : 2'd2);
    assign w_we1    = w_accept && !r_skip_first;
    assign w_wdata0 = r_skip_first ? fetch_data1 : fetch_data0;

    always_comb begin
        w_head_nxt        = r_head;
        w_tail_nxt        = r_tail;
        w_count_nxt       = r_count;
        w_discard_nxt     = r_discard;
        w_fetch_addr_nxt  = r_fetch_addr;
        w_skip_first_nxt  = r_skip_first;
        w_pc_nxt          = r_pc;
        // Counts every in-flight request, discarded or not.
        w_outstanding_nxt = r_outstanding + {1'b0, fetch_req} - {1'b0, fetch_valid};

        if (redirect) begin
            w_head_nxt       = r_tail;
            w_count_nxt      = '0;
            w_discard_nxt    = r_outstanding - {1'b0, fetch_valid};
            w_pc_nxt         = redirect_pc;
            w_fetch_addr_nxt = {redirect_pc[31:3], 3'b000};
            w_skip_first_nxt = redirect_pc[2];
        end else begin
            if (fetch_req) begin
                w_fetch_addr_nxt = r_fetch_addr + 32'(FETCH_BYTES);
            end
            if (fetch_valid && (r_discard != 2'd0)) begin
                w_discard_nxt = r_discard - 2'd1;
            end
            if (w_accept) begin
                w_tail_nxt       = r_tail + IDX_W'(w_enq);
                w_skip_first_nxt = 1'b0;
            end
            w_head_nxt  = r_head + IDX_W'(w_deq_eff);
            w_count_nxt = r_count + CNT_W'(w_enq) - CNT_W'(w_deq_eff);
            w_pc_nxt    = r_pc + {28'b0, w_deq_eff, 2'b00};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_fetch_addr  <= {RESET_PC[31:3], 3'b000};
            r_skip_first  <= RESET_PC[2];
            r_pc          <= RESET_PC;
        end else begin
            r_head        <= w_head_nxt;
            r_tail        <= w_tail_nxt;
            r_count       <= w_count_nxt;
            r_outstanding <= w_outstanding_nxt;
            r_discard     <= w_discard_nxt;
            r_fetch_addr  <= w_fetch_addr_nxt;
            r_skip_first  <= w_skip_first_nxt;
            r_pc          <= w_pc_nxt;
        end
    end

    fetchq_ram #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .i_clk    (clk),
        .i_we0    (w_accept),
        .i_we1    (w_we1),
        .i_waddr  (r_tail),
        .i_wdata0 (w_wdata0),
        .i_wdata1 (fetch_data1),
        .i_raddr  (r_head),
        .o_rdata0 (w_rdata0),
        .o_rdata1 (w_rdata1)
    );

    assign pc     = r_pc;
    assign avail  = w_avail;
    assign instr  = (r_count != '0) ? w_rdata0 : NOP_INSTR;
    assign instr2 = (r_count >= CNT_W'(2)) ? w_rdata1 : NOP_INSTR;

    a_count_bound: assert property (@(posedge clk) disable iff (reset) r_count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_dual_fetch_queue.sv
// Directed bench for dual_fetch_queue with an in-order imem model of
// configurable latency and a return-credit throttle.
module tb_dual_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_valid;
    logic [31:0] fetch_data0;
    logic [31:0] fetch_data1;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] instr2;
    logic [1:0]  avail;
    logic [1:0]  deq;
    logic        redirect;
    logic [31:0] redirect_pc;

    int n_checks = 0;
    int n_fail   = 0;

    int          cyc;
    int          lat;
    int          credit;
    logic [31:0] q_addr[$];
    int          q_at[$];
    logic [31:0] req_log[$];

    always #5 clk = ~clk;

    dual_fetch_queue #(
        .DEPTH    (8),
        .MAX_OUT  (2),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_valid (fetch_valid),
        .fetch_data0 (fetch_data0),
        .fetch_data1 (fetch_data1),
        .pc          (pc),
        .instr       (instr),
        .instr2      (instr2),
        .avail       (avail),
        .deq         (deq),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic imem_present();
        if (q_addr.size() != 0 && q_at[0] <= cyc && credit != 0) begin
            fetch_valid = 1'b1;
            fetch_data0 = mem_word(q_addr[0]);
            fetch_data1 = mem_word(q_addr[0] + 32'd4);
        end else begin
            fetch_valid = 1'b0;
            fetch_data0 = '0;
            fetch_data1 = '0;
        end
    endtask

    task automatic tick();
        logic        s_req;
        logic        s_val;
        logic [31:0] s_addr;
        #2;
        s_req  = fetch_req;
        s_val  = fetch_valid;
        s_addr = fetch_addr;
        @(posedge clk);
        #1;
        cyc++;
        if (s_val) begin
            void'(q_addr.pop_front());
            void'(q_at.pop_front());
            if (credit > 0) credit--;
        end
        if (s_req) begin
            q_addr.push_back(s_addr);
            q_at.push_back(cyc + lat - 1);
            req_log.push_back(s_addr);
        end
        imem_present();
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        deq         = 2'd0;
        redirect    = 1'b0;
        redirect_pc = '0;
        q_addr.delete();
        q_at.delete();
        req_log.delete();
        lat    = 1;
        credit = -1;
        cyc    = 0;
        imem_present();
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        deq = 2'd0; redirect = 1'b0; redirect_pc = '0;
        fetch_valid = 1'b0; fetch_data0 = '0; fetch_data1 = '0;
        #12;
        n_checks++;
        if (fetch_req !== 1'b0 || pc !== 32'h0 || fetch_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_ctl: req=%b pc=%h addr=%h required 0/0/0", fetch_req, pc, fetch_addr);
        end
        n_checks++;
        if (avail !== 2'd0 || instr !== 32'h0 || instr2 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_q: avail=%0d instr=%h instr2=%h required 0/0/0", avail, instr, instr2);
        end
        do_reset();
        n_checks++;
        if (fetch_req !== 1'b1 || fetch_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_release: req=%b addr=%h required 1/0", fetch_req, fetch_addr);
        end
    endtask

    task automatic test_fill();
        do_reset();
        tick();
        n_checks++;
        if (fetch_addr !== 32'h8) begin
            n_fail++;
            $display("FAIL fill_addr1: addr=%h required 00000008", fetch_addr);
        end
        repeat (8) tick();
        n_checks++;
        if (req_log.size() != 4 || req_log[0] !== 32'h0 || req_log[1] !== 32'h8 ||
            req_log[2] !== 32'h10 || req_log[3] !== 32'h18) begin
            n_fail++;
            $display("FAIL fill_reqs: %0d requests issued, required 4 at 0,8,10,18", req_log.size());
        end
        n_checks++;
        if (avail !== 2'd2 || pc !== 32'h0 || instr !== mem_word(32'h0) ||
            instr2 !== mem_word(32'h4)) begin
            n_fail++;
            $display("FAIL fill_out: avail=%0d pc=%h instr=%h instr2=%h required 2/0/%h/%h",
                     avail, pc, instr, instr2, mem_word(32'h0), mem_word(32'h4));
        end
        repeat (3) tick();
        n_checks++;
        if (fetch_req !== 1'b0 || req_log.size() != 4) begin
            n_fail++;
            $display("FAIL fill_full: req=%b reqs=%0d required 0/4", fetch_req, req_log.size());
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        do_reset();
        deq = 2'd2;
        tick();
        tick();
        exp_pc = 32'h0;
        for (int i = 0; i < 12; i++) begin
            n_checks++;
            if (avail !== 2'd2 || pc !== exp_pc || instr !== mem_word(exp_pc) ||
                instr2 !== mem_word(exp_pc + 32'd4)) begin
                n_fail++;
                $display("FAIL stream[%0d]: avail=%0d pc=%h instr=%h instr2=%h required 2/%h/%h/%h",
                         i, avail, pc, instr, instr2, exp_pc, mem_word(exp_pc),
                         mem_word(exp_pc + 32'd4));
            end
            tick();
            exp_pc = exp_pc + 32'd8;
        end
        deq = 2'd0;
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc;
        logic [1:0]  d;
        do_reset();
        repeat (9) tick();
        exp_pc = 32'h0;
        for (int i = 0; i < 20; i++) begin
            d = (i % 2 == 0) ? 2'd1 : 2'd2;
            n_checks++;
            if (avail !== 2'd2 || pc !== exp_pc || instr !== mem_word(exp_pc) ||
                instr2 !== mem_word(exp_pc + 32'd4)) begin
                n_fail++;
                $display("FAIL wrap[%0d]: avail=%0d pc=%h instr=%h instr2=%h required 2/%h/%h/%h",
                         i, avail, pc, instr, instr2, exp_pc, mem_word(exp_pc),
                         mem_word(exp_pc + 32'd4));
            end
            deq = d;
            tick();
            exp_pc = exp_pc + {28'b0, d, 2'b00};
        end
        deq = 2'd0;
    endtask

    task automatic test_redirect_outstanding();
        bit seen;
        do_reset();
        lat = 3;
        tick();
        tick();
        redirect = 1'b1;
        redirect_pc = 32'h0000_0104;
        #1;
        n_checks++;
        if (fetch_req !== 1'b0 || fetch_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_cycle: req=%b valid=%b required 0/0", fetch_req, fetch_valid);
        end
        req_log.delete();
        tick();
        redirect = 1'b0;
        #1;
        n_checks++;
        if (pc !== 32'h104 || fetch_addr !== 32'h100 || avail !== 2'd0) begin
            n_fail++;
            $display("FAIL redir_state: pc=%h addr=%h avail=%0d required 104/100/0",
                     pc, fetch_addr, avail);
        end
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (avail != 2'd0) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL redir_timeout: avail=%0d after 20 cycles, required nonzero", avail);
        end
        n_checks++;
        if (req_log.size() == 0 || req_log[0] !== 32'h100) begin
            n_fail++;
            $display("FAIL redir_first_fetch: %0d requests, first required 00000100",
                     req_log.size());
        end
        n_checks++;
        if (avail !== 2'd1 || pc !== 32'h104 || instr !== mem_word(32'h104) ||
            instr2 !== 32'h0) begin
            n_fail++;
            $display("FAIL redir_first_word: avail=%0d pc=%h instr=%h instr2=%h required 1/104/%h/0",
                     avail, pc, instr, instr2, mem_word(32'h104));
        end
        tick();
        n_checks++;
        if (avail !== 2'd2 || instr !== mem_word(32'h104) || instr2 !== mem_word(32'h108)) begin
            n_fail++;
            $display("FAIL redir_second: avail=%0d instr=%h instr2=%h required 2/%h/%h",
                     avail, instr, instr2, mem_word(32'h104), mem_word(32'h108));
        end
    endtask

    task automatic test_redirect_with_return();
        do_reset();
        tick();
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0040;
        deq         = 2'd2;
        #1;
        n_checks++;
        if (fetch_req !== 1'b0 || fetch_valid !== 1'b1 || avail !== 2'd2) begin
            n_fail++;
            $display("FAIL rv_cycle: req=%b valid=%b avail=%0d required 0/1/2",
                     fetch_req, fetch_valid, avail);
        end
        tick();
        redirect = 1'b0;
        deq      = 2'd0;
        #1;
        n_checks++;
        if (avail !== 2'd0 || instr !== 32'h0 || instr2 !== 32'h0 || pc !== 32'h40 ||
            fetch_addr !== 32'h40 || fetch_req !== 1'b1) begin
            n_fail++;
            $display("FAIL rv_flushed: avail=%0d instr=%h instr2=%h pc=%h addr=%h req=%b required 0/0/0/40/40/1",
                     avail, instr, instr2, pc, fetch_addr, fetch_req);
        end
        tick();
        tick();
        n_checks++;
        if (avail !== 2'd2 || instr !== mem_word(32'h40) || instr2 !== mem_word(32'h44)) begin
            n_fail++;
            $display("FAIL rv_refetch: avail=%0d instr=%h instr2=%h required 2/%h/%h",
                     avail, instr, instr2, mem_word(32'h40), mem_word(32'h44));
        end
    endtask

    task automatic test_deq_clamp_empty();
        do_reset();
        credit = 0;
        imem_present();
        repeat (3) tick();
        n_checks++;
        if (avail !== 2'd0 || instr !== 32'h0 || instr2 !== 32'h0 || fetch_req !== 1'b0) begin
            n_fail++;
            $display("FAIL clamp_start: avail=%0d instr=%h instr2=%h req=%b required 0/0/0/0",
                     avail, instr, instr2, fetch_req);
        end
        credit = 1;
        imem_present();
        tick();
        deq = 2'd1;
        tick();
        deq = 2'd2;
        #1;
        n_checks++;
        if (avail !== 2'd1 || pc !== 32'h4 || instr !== mem_word(32'h4) || instr2 !== 32'h0) begin
            n_fail++;
            $display("FAIL clamp_one: avail=%0d pc=%h instr=%h instr2=%h required 1/4/%h/0",
                     avail, pc, instr, instr2, mem_word(32'h4));
        end
        tick();
        deq = 2'd0;
        #1;
        n_checks++;
        if (avail !== 2'd0 || pc !== 32'h8 || instr !== 32'h0 || instr2 !== 32'h0) begin
            n_fail++;
            $display("FAIL clamp_empty: avail=%0d pc=%h instr=%h instr2=%h required 0/8/0/0",
                     avail, pc, instr, instr2);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        deq = 2'd2;
        repeat (6) tick();
        n_checks++;
        if (pc !== 32'h20 || avail !== 2'd2) begin
            n_fail++;
            $display("FAIL areset_pre: pc=%h avail=%0d required 20/2", pc, avail);
        end
        #3;
        reset = 1'b1;
        #1;
        n_checks++;
        if (pc !== 32'h0 || fetch_req !== 1'b0 || fetch_addr !== 32'h0 || avail !== 2'd0 ||
            instr !== 32'h0 || instr2 !== 32'h0) begin
            n_fail++;
            $display("FAIL areset_now: pc=%h req=%b addr=%h avail=%0d instr=%h instr2=%h required all 0",
                     pc, fetch_req, fetch_addr, avail, instr, instr2);
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_stream();
        test_wrap();
        test_redirect_outstanding();
        test_redirect_with_return();
        test_deq_clamp_empty();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
